// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button conditioning logic: FSM state
// encodings, the 24 MHz tick default and a counter-width helper.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // 1 ms debounce tick at the 24 MHz PLL clock.
    localparam int TICK_DIV_24MHZ = 24000;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_sync2.sv
// Two-flop synchronizer for one asynchronous pin; the reset value is a
// parameter so idle-high and idle-low pins can share it.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking keeps this a true two-stage shift; blocking would collapse it to one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizes the active-low pin, debounces it on a
// prescaled tick and emits press, release and long-press pulses.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_24MHZ,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic BTN_N,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DIV_W  = cnt_width(TICK_DIV - 1);
    localparam int DB_W   = cnt_width(DEBOUNCE_TICKS - 1);
    localparam int HOLD_W = cnt_width(LONG_TICKS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    logic              sync_out;
    logic              pressed_s;
    logic [DIV_W-1:0]  div_count;
    logic              tick;
    logic [DB_W-1:0]   db_count;
    logic [HOLD_W-1:0] hold_count;
    logic              long_done;
    logic              db_last;
    logic              releasing;
    logic              hold_step;
    state_t            state;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (BTN_N),
        .q     (sync_out)
    );

    assign pressed_s = ~sync_out;

    // The hold counter advances on every tick of the held press, including
    // ticks seen during a release bounce, but not on the tick that accepts the release.
    always_comb begin
        db_last   = tick && (db_count == DB_LAST);
        releasing = (state == ST_RELEASE_WAIT) && !pressed_s && db_last;
        hold_step = tick && !releasing &&
                    ((state == ST_PRESSED) || (state == ST_RELEASE_WAIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_count   <= '0;
            tick        <= 1'b0;
            state       <= ST_RELEASED;
            db_count    <= '0;
            hold_count  <= '0;
            long_done   <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;

            if (div_count == DIV_LAST) begin
                div_count <= '0;
                tick      <= 1'b1;
            end else begin
                div_count <= div_count + 1'b1;
                tick      <= 1'b0;
            end

            // A pin change always beats a tick arriving in the same cycle.
            case (state)
                ST_RELEASED: begin
                    if (pressed_s) begin
                        state    <= ST_PRESS_WAIT;
                        db_count <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state <= ST_RELEASED;
                    end else if (db_last) begin
                        state      <= ST_PRESSED;
                        btn_press  <= 1'b1;
                        btn_level  <= 1'b1;
                        hold_count <= '0;
                    end else if (tick) begin
                        db_count <= db_count + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!pressed_s) begin
                        state    <= ST_RELEASE_WAIT;
                        db_count <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (pressed_s) begin
                        state <= ST_PRESSED;
                    end else if (db_last) begin
                        state       <= ST_RELEASED;
                        btn_release <= 1'b1;
                        btn_level   <= 1'b0;
                        long_done   <= 1'b0;
                    end else if (tick) begin
                        db_count <= db_count + 1'b1;
                    end
                end
                default: state <= ST_RELEASED;
            endcase

            if (hold_step && (hold_count != HOLD_MAX)) begin
                hold_count <= hold_count + 1'b1;
                if ((hold_count == HOLD_LAST) && !long_done) begin
                    btn_long  <= 1'b1;
                    long_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=10.
module tb_btn_debounce;

    logic clk = 1'b0;
    logic reset;
    logic BTN_N;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_press = 0, n_release = 0, n_long = 0;
    int t_press = 0, t_release = 0, t_long = 0;
    int n_overlap = 0, n_level_err = 0;

    btn_debounce #(
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .LONG_TICKS     (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .BTN_N       (BTN_N),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (btn_press)   begin n_press++;   t_press   = cyc; end
        if (btn_release) begin n_release++; t_release = cyc; end
        if (btn_long)    begin n_long++;    t_long    = cyc; end
        if (int'(btn_press) + int'(btn_release) + int'(btn_long) > 1) n_overlap++;
        if ((btn_press && !btn_level) || (btn_release && btn_level)) n_level_err++;
    end

    task automatic check(input string tag, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", tag, actual, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({btn_level, btn_press, btn_release, btn_long});
    endfunction

    initial begin
        int t0, p0, r0, l0;

        // Reset and idle
        reset = 1'b1;
        BTN_N = 1'b1;
        step(5);
        check("reset_outputs", outs(), 0, 0);
        reset = 1'b0;
        step(50);
        check("idle_outputs", outs(), 0, 0);
        check("idle_pulses", n_press + n_release + n_long, 0, 0);

        // Clean press then clean release
        t0 = cyc;
        BTN_N = 1'b0;
        step(30);
        check("clean_press_count", n_press, 1, 1);
        check("clean_press_latency", t_press - t0, 11, 15);
        check("clean_press_level", int'(btn_level), 1, 1);
        t0 = cyc;
        BTN_N = 1'b1;
        step(30);
        check("clean_release_count", n_release, 1, 1);
        check("clean_release_latency", t_release - t0, 11, 15);
        check("clean_release_level", int'(btn_level), 0, 0);
        check("short_hold_no_long", n_long, 0, 0);

        // Press bounce rejected
        BTN_N = 1'b0;
        step(6);
        BTN_N = 1'b1;
        step(30);
        check("bounce_no_press", n_press, 1, 1);
        check("bounce_level", int'(btn_level), 0, 0);

        // Long press
        BTN_N = 1'b0;
        step(80);
        check("long_press_count", n_press, 2, 2);
        check("long_count", n_long, 1, 1);
        check("long_delay", t_long - t_press, 36, 40);
        check("long_level", int'(btn_level), 1, 1);

        // Release bounce while held
        BTN_N = 1'b1;
        step(5);
        BTN_N = 1'b0;
        step(20);
        check("rel_bounce_no_release", n_release, 1, 1);
        check("rel_bounce_no_press", n_press, 2, 2);
        check("rel_bounce_no_long_repeat", n_long, 1, 1);
        check("rel_bounce_level", int'(btn_level), 1, 1);

        // Clean release after the long press
        t0 = cyc;
        BTN_N = 1'b1;
        step(30);
        check("long_release_count", n_release, 2, 2);
        check("long_release_latency", t_release - t0, 11, 15);
        check("long_release_level", int'(btn_level), 0, 0);

        // Reset while pressed, pin stays low
        BTN_N = 1'b0;
        step(30);
        check("pre_reset_level", int'(btn_level), 1, 1);
        p0 = n_press;
        r0 = n_release;
        l0 = n_long;
        reset = 1'b1;
        step(1);
        check("mid_reset_outputs", outs(), 0, 0);
        reset = 1'b0;
        t0 = cyc;
        step(20);
        check("mid_reset_no_release", n_release, r0, r0);
        check("mid_reset_no_long", n_long, l0, l0);
        check("post_reset_press_count", n_press, p0 + 1, p0 + 1);
        check("post_reset_press_latency", t_press - t0, 11, 15);
        check("post_reset_level", int'(btn_level), 1, 1);

        check("pulse_overlap", n_overlap, 0, 0);
        check("pulse_level_align", n_level_err, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
